unidade_busca: RTL
==================

// Module: unidade_busca
// PURPOSE
// Instruction-fetch stage directly upstream of RAM_instrucoes. Holds the PC as a (linha, coluna) pair,
// drives end_linha/end_coluna, latches the returned 32-bit word into an instruction register and hands
// it to the control unit with a valid/accept handshake. Handles sequential advance with row wrap,
// register-supplied jump targets, HLT detection and the post-reset wait while the RAM self-loads.
// PARAMETERS
// TAMANHO        40   matrix side; legal linha/coluna are 0..TAMANHO-1 (must match RAM_instrucoes)
// ESPERA_INICIAL 2    cycles held in INICIO after reset before the first fetch (RAM loads on 1st edge)
// OP_HLT         5'b11011  opcode (instr[31:27]) that halts fetching
// PORTS
// clock            in   1   system clock, all state on posedge
// reset            in   1   asynchronous, active-high
// instrucao_in     in   32  word from RAM_instrucoes.saida
// proximo          in   1   control accepts current IR, fetch PC+1
// salto            in   1   control accepts current IR, fetch salto_linha/salto_coluna
// salto_linha      in   11  jump target row
// salto_coluna     in   11  jump target column
// end_linha        out  11  PC row, to RAM_instrucoes.end_linha
// end_coluna       out  11  PC column, to RAM_instrucoes.end_coluna
// instrucao        out  32  instruction register
// instrucao_valida out  1   IR holds a fetched word not yet accepted
// parado           out  1   HLT fetched; sticky until reset
// erro_endereco    out  1   sticky: a jump target was out of range
// contador_instr   out  16  number of words captured, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (async, clock-independent): state=INICIO, wait counter=0, PC=(0,0), instrucao=0, all flags 0,
//   contador_instr=0. Reset asserted mid-operation aborts any fetch immediately; IR content discarded.
// - States: INICIO -> BUSCA -> CAPTURA -> ESPERA -> (BUSCA | PARADO).
// - INICIO: counts ESPERA_INICIAL edges after reset release, then BUSCA. proximo/salto ignored.
// - BUSCA: PC held stable for one full cycle (RAM read settles); next state CAPTURA.
// - CAPTURA: instrucao<=instrucao_in, instrucao_valida<=1, contador_instr++ (saturating).
//   If instrucao_in[31:27]==OP_HLT: parado<=1, next PARADO; else next ESPERA.
// - ESPERA: instrucao_valida=1, IR stable. On edge with salto=1: PC<=target, valida<=0, -> BUSCA.
//   Else on proximo=1: PC<=PC+1, valida<=0, -> BUSCA. Neither: hold. salto has priority over proximo.
// - PC+1: coluna<TAMANHO-1 -> coluna+1; coluna==TAMANHO-1 -> coluna=0, linha+1; (TAMANHO-1,TAMANHO-1) -> (0,0).
// - Jump target: any coordinate >= TAMANHO is replaced by 0 for that coordinate, erro_endereco<=1.
// - PARADO: instrucao_valida stays 1 holding the HLT word, parado=1, PC frozen; proximo/salto ignored;
//   only reset leaves PARADO.
// - Latency: accept edge -> instrucao_valida high again 3 edges later (BUSCA, CAPTURA, ESPERA).
//   First valid word after reset release: ESPERA_INICIAL+2 edges.
// - proximo/salto sampled only in ESPERA; pulses in other states are lost, not queued.
// - All outputs are registers; no combinational path from inputs to outputs.
// TESTING
// - Reset, RAM with NOP at [0][0]: release reset -> end=(0,0), valida rises on edge 4, instrucao=32'hD0000000, contador=1.
// - Hold proximo=1 continuously: addresses (0,0),(0,1),(0,2)... one per 3 cycles; at (0,39) next is (1,0); at (39,39) next is (0,0).
// - In ESPERA at (0,18) pulse salto with target (0,9) and proximo=1 same edge -> next address (0,9), not (0,19).
// - Jump to (45,3) -> address (0,3), erro_endereco=1 and stays 1 through later legal jumps.
// - Word 32'hD8000000 (HLT) at (0,23) -> parado=1, valida=1, PC stays (0,23) for 20 cycles of proximo/salto.
// - Assert reset during BUSCA of (0,5) -> outputs immediately (0,0)/0 without a clock edge; refetch restarts after ESPERA_INICIAL.

Source files
------------

// File: rtl/unidade_busca.sv
// Instruction-fetch stage feeding RAM_instrucoes: keeps the PC as (linha, coluna),
// captures the returned word into the IR and offers it to control with a valid/accept handshake.
module unidade_busca #(
  parameter int          TAMANHO        = 40,
  parameter int          ESPERA_INICIAL = 2,
  parameter logic [4:0]  OP_HLT         = 5'b11011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrucao_in,
  input  logic        proximo,
  input  logic        salto,
  input  logic [10:0] salto_linha,
  input  logic [10:0] salto_coluna,
  output logic [10:0] end_linha,
  output logic [10:0] end_coluna,
  output logic [31:0] instrucao,
  output logic        instrucao_valida,
  output logic        parado,
  output logic        erro_endereco,
  output logic [15:0] contador_instr
);

  localparam logic [2:0] INICIO  = 3'd0;
  localparam logic [2:0] BUSCA   = 3'd1;
  localparam logic [2:0] CAPTURA = 3'd2;
  localparam logic [2:0] ESPERA  = 3'd3;
  localparam logic [2:0] PARADO  = 3'd4;

  localparam logic [10:0] LIMITE     = 11'(TAMANHO);
  localparam logic [10:0] ULTIMO     = 11'(TAMANHO - 1);
  // ESPERA_INICIAL must be at least 1: the RAM needs its first edge to load.
  localparam logic [7:0]  ESPERA_FIM = 8'(ESPERA_INICIAL - 1);

  logic [2:0]  estado_q, estado_d;
  logic [7:0]  espera_q, espera_d;
  logic [10:0] linha_q, linha_d;
  logic [10:0] coluna_q, coluna_d;
  logic [31:0] instr_q, instr_d;
  logic        valida_q, valida_d;
  logic        parado_q, parado_d;
  logic        erro_q, erro_d;
  logic [15:0] cont_q, cont_d;

  always_comb begin
    estado_d = estado_q;
    espera_d = espera_q;
    linha_d  = linha_q;
    coluna_d = coluna_q;
    instr_d  = instr_q;
    valida_d = valida_q;
    parado_d = parado_q;
    erro_d   = erro_q;
    cont_d   = cont_q;

    case (estado_q)
      INICIO: begin
        if (espera_q >= ESPERA_FIM) begin
          estado_d = BUSCA;
        end else begin
          espera_d = espera_q + 8'd1;
        end
      end
      BUSCA: begin
        estado_d = CAPTURA;
      end
      CAPTURA: begin
        instr_d  = instrucao_in;
        valida_d = 1'b1;
        if (cont_q != 16'hFFFF) begin
          cont_d = cont_q + 16'd1;
        end
        if (instrucao_in[31:27] == OP_HLT) begin
          parado_d = 1'b1;
          estado_d = PARADO;
        end else begin
          estado_d = ESPERA;
        end
      end
      ESPERA: begin
        // Jump wins over sequential advance; out-of-range coordinates fold to 0.
        if (salto) begin
          valida_d = 1'b0;
          estado_d = BUSCA;
          if (salto_linha >= LIMITE) begin
            linha_d = 11'd0;
            erro_d  = 1'b1;
          end else begin
            linha_d = salto_linha;
          end
          if (salto_coluna >= LIMITE) begin
            coluna_d = 11'd0;
            erro_d   = 1'b1;
          end else begin
            coluna_d = salto_coluna;
          end
        end else if (proximo) begin
          valida_d = 1'b0;
          estado_d = BUSCA;
          if (coluna_q < ULTIMO) begin
            coluna_d = coluna_q + 11'd1;
          end else begin
            coluna_d = 11'd0;
            linha_d  = (linha_q < ULTIMO) ? linha_q + 11'd1 : 11'd0;
          end
        end
      end
      PARADO: begin
        estado_d = PARADO;
      end
      default: begin
        estado_d = INICIO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIO;
      espera_q <= 8'd0;
      linha_q  <= 11'd0;
      coluna_q <= 11'd0;
      instr_q  <= 32'd0;
      valida_q <= 1'b0;
      parado_q <= 1'b0;
      erro_q   <= 1'b0;
      cont_q   <= 16'd0;
    end else begin
      estado_q <= estado_d;
      espera_q <= espera_d;
      linha_q  <= linha_d;
      coluna_q <= coluna_d;
      instr_q  <= instr_d;
      valida_q <= valida_d;
      parado_q <= parado_d;
      erro_q   <= erro_d;
      cont_q   <= cont_d;
    end
  end

  assign end_linha        = linha_q;
  assign end_coluna       = coluna_q;
  assign instrucao        = instr_q;
  assign instrucao_valida = valida_q;
  assign parado           = parado_q;
  assign erro_endereco    = erro_q;
  assign contador_instr   = cont_q;

endmodule
